// File: rtl/l1_trigger_event_fifo_if.sv
// Event stream from the L1 trigger event FIFO toward the TURF readout path (valid/ready).
interface l1_trigger_event_fifo_if #(
  parameter int DATA_W = 34
);
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;

  modport master (output tdata, output tvalid, input  tready);
  modport slave  (input  tdata, input  tvalid, output tready);
endinterface

// File: rtl/l1_trigger_event_fifo.sv
// Merges beam triggers inside a COINC_WINDOW into {mask, timestamp} events, queued in a FWFT FIFO.
// Trigger-to-tvalid 5 clocks; stalls hold tdata, pushes into a full FIFO are dropped and counted. Option: L1_EVENT_FIFO_SEQNUM_EN.
module l1_trigger_event_fifo #(
  parameter int NBEAMS         = 2,
  parameter int TIMESTAMP_BITS = 32,
  parameter int COINC_WINDOW   = 4,
  parameter int FIFO_DEPTH     = 16
) (
  input  logic                    aclk,
  input  logic                    reset_i,
  input  logic [NBEAMS-1:0]       trigger_i,
  input  logic                    enable_i,
  input  logic                    tstamp_rst_i,
  l1_trigger_event_fifo_if.master m,
  output logic                    overflow_o,
  input  logic                    clr_overflow_i,
  output logic [15:0]             drop_count_o
);

`ifdef L1_EVENT_FIFO_SEQNUM_EN
  localparam int SEQ_W = 16;
`else
  localparam int SEQ_W = 0;
`endif
  localparam int DATA_W = SEQ_W + NBEAMS + TIMESTAMP_BITS;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int WIN_W  = (COINC_WINDOW > 1) ? $clog2(COINC_WINDOW) : 1;

  typedef enum logic [1:0] {IDLE, GATHER, PUSH} state_t;

  state_t                    state_q, state_d;
  logic [NBEAMS-1:0]         mask_q, mask_d;
  logic [TIMESTAMP_BITS-1:0] ts_q;
  logic [TIMESTAMP_BITS-1:0] ts_cap_q, ts_cap_d;
  logic [WIN_W-1:0]          win_q, win_d;
  logic                      push;

  logic [DATA_W-1:0]         mem [FIFO_DEPTH];
  logic [PTR_W:0]            wr_ptr, rd_ptr;
  logic                      empty, full, push_ok, pop, drop;
  logic [DATA_W-1:0]         ev_dat;

  always_ff @(posedge aclk or posedge reset_i) begin
    if (reset_i)           ts_q <= '0;
    else if (tstamp_rst_i) ts_q <= '0;
    else                   ts_q <= ts_q + TIMESTAMP_BITS'(1);
  end

  always_ff @(posedge aclk or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      mask_q   <= '0;
      ts_cap_q <= '0;
      win_q    <= '0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      ts_cap_q <= ts_cap_d;
      win_q    <= win_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    ts_cap_d = ts_cap_q;
    win_d    = win_q;
    push     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable_i && |trigger_i) begin
          ts_cap_d = ts_q;
          mask_d   = trigger_i;
          win_d    = WIN_W'(COINC_WINDOW - 1);
          state_d  = (COINC_WINDOW > 1) ? GATHER : PUSH;
        end
      end
      GATHER: begin
        // enable_i is not consulted: an opened window always completes
        mask_d = mask_q | trigger_i;
        win_d  = win_q - WIN_W'(1);
        if (win_q == WIN_W'(1)) state_d = PUSH;
      end
      PUSH: begin
        push    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef L1_EVENT_FIFO_SEQNUM_EN
  logic [15:0] seq_q;

  // Advances on dropped events too, so gaps in the stream expose losses
  always_ff @(posedge aclk or posedge reset_i) begin
    if (reset_i)           seq_q <= '0;
    else if (tstamp_rst_i) seq_q <= '0;
    else if (push)         seq_q <= seq_q + 16'd1;
  end

  assign ev_dat = {seq_q, mask_q, ts_cap_q};
`else
  assign ev_dat = {mask_q, ts_cap_q};
`endif

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  // Fullness is judged before this cycle's pop, so a concurrent pop does not rescue a push
  assign push_ok = push && !full;
  assign drop    = push && full;
  assign pop     = !empty && m.tready;

  always_ff @(posedge aclk) begin
    if (push_ok) mem[wr_ptr[PTR_W-1:0]] <= ev_dat;
  end

  always_ff @(posedge aclk or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      if (pop)     rd_ptr <= rd_ptr + (PTR_W+1)'(1);
    end
  end

  assign m.tvalid = !empty;
  assign m.tdata  = empty ? '0 : mem[rd_ptr[PTR_W-1:0]];

  // A drop coinciding with a clear is counted after the clear
  always_ff @(posedge aclk or posedge reset_i) begin
    if (reset_i) begin
      overflow_o   <= 1'b0;
      drop_count_o <= '0;
    end else if (clr_overflow_i) begin
      overflow_o   <= drop;
      drop_count_o <= {15'd0, drop};
    end else if (drop) begin
      overflow_o <= 1'b1;
      if (drop_count_o != 16'hFFFF) drop_count_o <= drop_count_o + 16'd1;
    end
  end

endmodule
